viterbi_frame_sched: RTL

Frame-level scheduler in front of `viterbi_core`. It accepts frame descriptors from the host into a small job queue and drives the core's per-frame configuration. It sequences each frame as sync-reset, gap, start pulse, then wait for `frame_done`, and reports per-job completion with a tag. An optional watchdog aborts frames that never complete.

---
 rtl/viterbi_sched_pkg.sv | 41 ++++
 rtl/viterbi_job_fifo.sv | 57 +++++
 rtl/viterbi_frame_sched.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/viterbi_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : viterbi_sched_pkg
// Brief    : Shared job descriptor, scheduler states and field widths.
// Revision : 1.0 - initial release
// ============================================================================
package viterbi_sched_pkg;

   localparam int c_SRC_ADDR_W    = 12;
   localparam int c_DST_ADDR_W    = 12;
   localparam int c_INFOBIT_LEN_W = 12;
   localparam int c_DEC_LEN_W     = 13;
   localparam int c_TAG_W_MAX     = 16;

   typedef struct packed {
      logic [c_TAG_W_MAX-1:0]     tag;
      logic [c_SRC_ADDR_W-1:0]    src;
      logic [c_DST_ADDR_W-1:0]    dst;
      logic [c_INFOBIT_LEN_W-1:0] infobit_len;
      logic [c_DEC_LEN_W-1:0]     dec_len;
      logic                       tail_biting;
   } job_t;

   localparam int c_JOB_W = $bits(job_t);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RST   = 3'd1,
      ST_GAP   = 3'd2,
      ST_START = 3'd3,
      ST_WAIT  = 3'd4,
      ST_DONE  = 3'd5
   } sched_state_e;

   // Counter width that stays legal for a count of one.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/viterbi_job_fifo.sv
`default_nettype none
// ============================================================================
// Module   : viterbi_job_fifo
// Brief    : Synchronous job descriptor FIFO with wrap-bit pointers.
// Revision : 1.0 - initial release
// ============================================================================
module viterbi_job_fifo
   import viterbi_sched_pkg::*;
#(
   parameter int QDEPTH = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_an_i,
   input  logic                      push_i,
   input  logic [c_JOB_W-1:0]        push_data_i,
   input  logic                      pop_i,
   output logic [c_JOB_W-1:0]        pop_data_o,
   output logic                      full_o,
   output logic                      empty_o,
   output logic [$clog2(QDEPTH):0]   level_o
);

   localparam int c_AW = $clog2(QDEPTH);

   logic [c_JOB_W-1:0] r_mem [QDEPTH];
   logic [c_AW:0]      r_wr_ptr;
   logic [c_AW:0]      r_rd_ptr;
   logic               w_push;
   logic               w_pop;

   assign full_o  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                    (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
   assign empty_o = (r_wr_ptr == r_rd_ptr);
   assign level_o = r_wr_ptr - r_rd_ptr;
   assign w_push  = push_i && !full_o;
   assign w_pop   = pop_i && !empty_o;

   assign pop_data_o = r_mem[r_rd_ptr[c_AW-1:0]];

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem[r_wr_ptr[c_AW-1:0]] <= push_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_an_i) begin
      if (!rst_an_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/viterbi_frame_sched.sv
`default_nettype none
// ============================================================================
// Module   : viterbi_frame_sched
// Brief    : Frame scheduler for viterbi_core: queue, reset/gap/start, done.
//            Define VITERBI_SCHED_WDOG_EN to build in the WAIT watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module viterbi_frame_sched
   import viterbi_sched_pkg::*;
#(
   parameter int QDEPTH      = 4,
   parameter int RST_CYC     = 4,
   parameter int TIMEOUT_CYC = 65535,
   parameter int TAG_W       = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_an_i,
   input  logic                       job_valid_i,
   output logic                       job_ready_o,
   input  logic [TAG_W-1:0]           job_tag_i,
   input  logic [c_SRC_ADDR_W-1:0]    job_src_addr_i,
   input  logic [c_DST_ADDR_W-1:0]    job_dst_addr_i,
   input  logic [c_INFOBIT_LEN_W-1:0] job_infobit_len_i,
   input  logic [c_DEC_LEN_W-1:0]     job_dec_len_i,
   input  logic                       job_tail_biting_i,
   output logic                       core_rst_sync_o,
   output logic                       core_frame_start_o,
   output logic [c_SRC_ADDR_W-1:0]    core_src_start_addr_o,
   output logic [c_DST_ADDR_W-1:0]    core_dst_start_addr_o,
   output logic [c_INFOBIT_LEN_W-1:0] core_infobit_length_o,
   output logic [c_DEC_LEN_W-1:0]     core_decoding_length_o,
   output logic                       core_tail_biting_en_o,
   input  logic                       core_frame_done_i,
   output logic                       done_o,
   output logic [TAG_W-1:0]           done_tag_o,
   output logic                       done_err_o,
   output logic                       busy_o,
   output logic [$clog2(QDEPTH):0]    q_level_o
);

   localparam int               c_CNT_W    = cnt_w(RST_CYC);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(RST_CYC - 1);

   sched_state_e        r_state;
   logic [c_CNT_W-1:0]  r_cnt;
   logic [TAG_W-1:0]    r_tag;
   job_t                w_push_job;
   job_t                w_head;
   logic                w_full;
   logic                w_empty;
   logic                w_pop;
   logic                w_tag_unused;

   always_comb begin
      w_push_job                 = '0;
      w_push_job.tag[TAG_W-1:0]  = job_tag_i;
      w_push_job.src             = job_src_addr_i;
      w_push_job.dst             = job_dst_addr_i;
      w_push_job.infobit_len     = job_infobit_len_i;
      w_push_job.dec_len         = job_dec_len_i;
      w_push_job.tail_biting     = job_tail_biting_i;
   end

   assign w_pop        = (r_state == ST_IDLE) && !w_empty;
   assign job_ready_o  = !w_full;
   assign busy_o       = (r_state != ST_IDLE) || !w_empty;
   assign w_tag_unused = &{1'b0, w_head.tag};

   viterbi_job_fifo #(
      .QDEPTH (QDEPTH)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_an_i    (rst_an_i),
      .push_i      (job_valid_i),
      .push_data_i (w_push_job),
      .pop_i       (w_pop),
      .pop_data_o  (w_head),
      .full_o      (w_full),
      .empty_o     (w_empty),
      .level_o     (q_level_o)
   );

`ifdef VITERBI_SCHED_WDOG_EN
   logic [31:0] r_wd;
   logic [31:0] w_wd_next;
   logic        r_done_err;

   assign w_wd_next  = r_wd + 32'd1;
   assign done_err_o = r_done_err;
`else
   localparam int c_timeout_unused = TIMEOUT_CYC;
   assign done_err_o = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_an_i) begin
      if (!rst_an_i) begin
         r_state                <= ST_IDLE;
         r_cnt                  <= '0;
         r_tag                  <= '0;
         core_rst_sync_o        <= 1'b0;
         core_frame_start_o     <= 1'b0;
         core_src_start_addr_o  <= '0;
         core_dst_start_addr_o  <= '0;
         core_infobit_length_o  <= '0;
         core_decoding_length_o <= '0;
         core_tail_biting_en_o  <= 1'b0;
         done_o                 <= 1'b0;
         done_tag_o             <= '0;
`ifdef VITERBI_SCHED_WDOG_EN
         r_wd                   <= '0;
         r_done_err             <= 1'b0;
`endif
      end else begin
         core_frame_start_o <= 1'b0;
         done_o             <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (!w_empty) begin
                  core_src_start_addr_o  <= w_head.src;
                  core_dst_start_addr_o  <= w_head.dst;
                  core_infobit_length_o  <= w_head.infobit_len;
                  core_decoding_length_o <= w_head.dec_len;
                  core_tail_biting_en_o  <= w_head.tail_biting;
                  r_tag                  <= w_head.tag[TAG_W-1:0];
                  core_rst_sync_o        <= 1'b1;
                  r_cnt                  <= '0;
                  r_state                <= ST_RST;
               end
            end
            ST_RST: begin
               if (r_cnt == c_CNT_LAST) begin
                  core_rst_sync_o <= 1'b0;
                  r_cnt           <= '0;
                  r_state         <= ST_GAP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_GAP: begin
               if (r_cnt == c_CNT_LAST) begin
                  core_frame_start_o <= 1'b1;
                  r_cnt              <= '0;
                  r_state            <= ST_START;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_START: begin
`ifdef VITERBI_SCHED_WDOG_EN
               r_wd    <= '0;
`endif
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               // A real completion takes priority over a coincident timeout.
               if (core_frame_done_i) begin
                  done_o     <= 1'b1;
                  done_tag_o <= r_tag;
`ifdef VITERBI_SCHED_WDOG_EN
                  r_done_err <= 1'b0;
`endif
                  r_state    <= ST_DONE;
               end
`ifdef VITERBI_SCHED_WDOG_EN
               else if (w_wd_next == 32'(TIMEOUT_CYC)) begin
                  done_o     <= 1'b1;
                  done_tag_o <= r_tag;
                  r_done_err <= 1'b1;
                  r_state    <= ST_DONE;
               end else begin
                  r_wd <= w_wd_next;
               end
`endif
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
